// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the decode sequencer: FSM states, format codes, opcodes, PC defaults.
// The TRAP state is only present when ILLEGAL_TRAP_EN is defined.
package decode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP    = 3'd5
`endif
  } state_e;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;

  // Formats whose instructions carry a destination register.
  function automatic logic writes_rd(input logic [2:0] fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  endfunction

endpackage

// File: rtl/decode_sequencer_classify.sv
// Combinational opcode-to-format classifier used by the decode sequencer.
module opcode_format_classify
  import decode_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] format
);

  always_comb begin
    format = FMT_NONE;
    case (opcode)
      OP_REG:                     format = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   format = FMT_I;
      OP_STORE:                   format = FMT_S;
      OP_BRANCH:                  format = FMT_B;
      OP_LUI, OP_AUIPC:           format = FMT_U;
      OP_JAL:                     format = FMT_J;
      default:                    format = FMT_NONE;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// Fetch/decode/execute/writeback sequencer for a single-issue core.
// Define ILLEGAL_TRAP_EN to redirect illegal opcodes to TRAP_VECTOR; otherwise they retire as NOPs.
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_q,
  output logic [2:0]  dec_sel,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        rf_we,
  output logic        illegal
);

  state_e      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_next_reg;
  logic [31:0] instr_reg;
  logic [2:0]  dec_sel_reg;
  logic        ex_start_reg;
  logic [2:0]  fmt;

  opcode_format_classify u_classify (
    .opcode (instr_reg[6:0]),
    .format (fmt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      pc_next_reg  <= RESET_PC;
      instr_reg    <= '0;
      dec_sel_reg  <= FMT_NONE;
      ex_start_reg <= 1'b0;
    end else begin
      ex_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: state_reg <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            instr_reg <= imem_rdata;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          dec_sel_reg <= fmt;
          if (fmt != FMT_NONE) begin
            state_reg    <= ST_EXECUTE;
            ex_start_reg <= 1'b1;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_reg   <= ST_TRAP;
`else
            pc_next_reg <= pc_reg + 32'd4;
            state_reg   <= ST_WRITEBACK;
`endif
          end
        end
        ST_EXECUTE: begin
          if (ex_done) begin
            pc_next_reg <= branch_taken ? branch_target : pc_reg + 32'd4;
            state_reg   <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          pc_reg    <= pc_next_reg;
          state_reg <= ST_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP: begin
          pc_reg    <= TRAP_VECTOR;
          state_reg <= ST_FETCH;
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = (state_reg == ST_FETCH);
  assign imem_addr = pc_reg;
  assign pc_out    = pc_reg;
  assign instr_q   = instr_reg;
  assign dec_sel   = dec_sel_reg;
  assign ex_start  = ex_start_reg;
  // Writes to x0 are suppressed; an illegal NOP has FMT_NONE and never writes.
  assign rf_we     = (state_reg == ST_WRITEBACK) && writes_rd(dec_sel_reg) && (instr_reg[11:7] != 5'd0);

`ifdef ILLEGAL_TRAP_EN
  assign illegal   = (state_reg == ST_TRAP);
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign illegal   = 1'b0;
`endif

endmodule
